pid_secuencial: RTL and testbench

- Parametrised successor of the loop's PD stage: a discrete PID controller with one time-shared multiplier, driven by a Start/Listo handshake.
- Sits between the sampled-feedback register (y) and the output-offset/PWM stage.
- Adds beyond the PD stage: integral term with conditional-integration anti-windup, runtime gains, output saturation flag, state clear.

---
 rtl/pid_secuencial.sv | 249 ++++++++++++++++++++++++
 tb/tb_pid_secuencial.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pid_secuencial.sv
// -----------------------------------------------------------------------------
// pid_secuencial
//
// Discrete PID controller that shares one signed multiplier across the P, I
// and D terms. A Start request is accepted only in IDLE. The controller then
// walks ERR -> MUL_P -> MUL_I -> MUL_D -> SUM -> DONE, one cycle per state.
// In DONE the new U and Sat are visible and Listo pulses for that one cycle.
//
// Arithmetic:
//   sat(x)   clips x to [-2^(W-1), 2^(W-1)-1].
//   mul(a,b) sat((a*b) >>> F). The product is the full 2W-bit value and the
//            shift is arithmetic.
//   e  = sat(r - y),            de = sat(e - e_prev)
//   P  = mul(Kp, e),            I_new = sat(I_acc + mul(Ki, e)),
//   D  = mul(Kd, de),           s = P + I_new + D (W+2 bits),
//   U  = sat(s),                Sat = (s != U)
//
// Anti-windup (AW=1): I_acc keeps its old value when the sum saturates in the
// same direction as the error. Otherwise I_acc takes I_new.
//
// Ports:
//   CLK          rising-edge clock
//   Reset        synchronous, active-high; clears all state and outputs
//   Start        request one update (IDLE only)
//   Clear        zero I_acc and e_prev (IDLE only, applied before Start)
//   r, y         signed setpoint / measurement
//   Kp, Ki, Kd   signed gains, Q(W-F).F
//   U            signed control output, held between updates
//   Listo        one-cycle pulse in DONE
//   Busy         high in every state except IDLE
//   Sat          1 when the last U was clipped
//   o_dbg_state  current FSM state (debug)
//   o_dbg_iacc   current integral accumulator (debug)
//
// Handshake: Start is sampled on a rising edge. It is accepted only while
// Busy=0, and there is no queueing. Listo is a one-cycle pulse. U and Sat are
// valid from the Listo cycle until the next DONE or until Reset.
// -----------------------------------------------------------------------------
module pid_secuencial #(
    parameter int W  = 19,
    parameter int F  = 8,
    parameter int AW = 1
) (
    input  logic                CLK,
    input  logic                Reset,
    input  logic                Start,
    input  logic                Clear,
    input  logic signed [W-1:0] r,
    input  logic signed [W-1:0] y,
    input  logic signed [W-1:0] Kp,
    input  logic signed [W-1:0] Ki,
    input  logic signed [W-1:0] Kd,
    output logic signed [W-1:0] U,
    output logic                Listo,
    output logic                Busy,
    output logic                Sat,
    output logic [2:0]          o_dbg_state,
    output logic signed [W-1:0] o_dbg_iacc
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ERR   = 3'd1,
        S_MUL_P = 3'd2,
        S_MUL_I = 3'd3,
        S_MUL_D = 3'd4,
        S_SUM   = 3'd5,
        S_DONE  = 3'd6
    } state_t;

    localparam logic signed [W-1:0] MAXV = {1'b0, {(W-1){1'b1}}};
    localparam logic signed [W-1:0] MINV = {1'b1, {(W-1){1'b0}}};

    // Saturating narrowers. A value fits in W bits exactly when every bit
    // above the W-bit sign bit repeats that sign bit.
    function automatic logic signed [W-1:0] sat_w1(input logic signed [W:0] x);
        if (x[W] != x[W-1])
            return x[W] ? MINV : MAXV;
        return x[W-1:0];
    endfunction

    function automatic logic signed [W-1:0] sat_w2(input logic signed [W+1:0] x);
        if ((x[W+1:W-1] == '0) || (x[W+1:W-1] == '1))
            return x[W-1:0];
        return x[W+1] ? MINV : MAXV;
    endfunction

    function automatic logic signed [W-1:0] sat_2w(input logic signed [2*W-1:0] x);
        if ((x[2*W-1:W-1] == '0) || (x[2*W-1:W-1] == '1))
            return x[W-1:0];
        return x[2*W-1] ? MINV : MAXV;
    endfunction

    state_t r_state;
    state_t w_next;

    // Operands captured at acceptance
    logic signed [W-1:0] r_r, r_y, r_kp, r_ki, r_kd;
    // Pipeline registers
    logic signed [W-1:0] r_e, r_de, r_p, r_inew, r_d;
    // Persistent controller state
    logic signed [W-1:0] r_iacc, r_eprev;
    // Outputs
    logic signed [W-1:0] r_u;
    logic                r_sat;

    // Error stage, computed one bit wider and then clipped
    logic signed [W:0]   w_diff_e, w_diff_de;
    logic signed [W-1:0] w_e, w_de;

    assign w_diff_e  = $signed({r_r[W-1], r_r}) - $signed({r_y[W-1], r_y});
    assign w_e       = sat_w1(w_diff_e);
    // de uses the error computed in this same cycle
    assign w_diff_de = $signed({w_e[W-1], w_e}) - $signed({r_eprev[W-1], r_eprev});
    assign w_de      = sat_w1(w_diff_de);

    // Shared multiplier. The operands are chosen by state.
    logic signed [W-1:0]   w_ma, w_mb;
    logic signed [2*W-1:0] w_ma_x, w_mb_x, w_prod, w_shift;
    logic signed [W-1:0]   w_mul;

    always_comb begin
        w_ma = '0;
        w_mb = '0;
        case (r_state)
            S_MUL_P: begin w_ma = r_kp; w_mb = r_e;  end
            S_MUL_I: begin w_ma = r_ki; w_mb = r_e;  end
            S_MUL_D: begin w_ma = r_kd; w_mb = r_de; end
            default: ;
        endcase
    end

    assign w_ma_x  = $signed({{W{w_ma[W-1]}}, w_ma});
    assign w_mb_x  = $signed({{W{w_mb[W-1]}}, w_mb});
    assign w_prod  = w_ma_x * w_mb_x;
    assign w_shift = w_prod >>> F;
    assign w_mul   = sat_2w(w_shift);

    // Integral candidate
    logic signed [W:0]   w_isum_x;
    logic signed [W-1:0] w_isum;

    assign w_isum_x = $signed({r_iacc[W-1], r_iacc}) + $signed({w_mul[W-1], w_mul});
    assign w_isum   = sat_w1(w_isum_x);

    // Final sum: three W-bit terms need at most W+2 bits
    logic signed [W+1:0] w_s;
    logic signed [W-1:0] w_u_next;
    logic                w_s_ovf, w_e_pos, w_e_neg, w_hold;

    assign w_s      = $signed({{2{r_p[W-1]}}, r_p})
                    + $signed({{2{r_inew[W-1]}}, r_inew})
                    + $signed({{2{r_d[W-1]}}, r_d});
    assign w_u_next = sat_w2(w_s);
    assign w_s_ovf  = !((w_s[W+1:W-1] == '0) || (w_s[W+1:W-1] == '1));
    assign w_e_pos  = !r_e[W-1] && (r_e != '0);
    assign w_e_neg  = r_e[W-1];
    // The integral is frozen only while it would push further into the
    // direction that is already clipped.
    assign w_hold   = (AW != 0) && w_s_ovf &&
                      ((!w_s[W+1] && w_e_pos) || (w_s[W+1] && w_e_neg));

    // Next state and decoded outputs
    always_comb begin
        w_next = r_state;
        Busy   = 1'b1;
        Listo  = 1'b0;
        case (r_state)
            S_IDLE: begin
                Busy = 1'b0;
                if (Start)
                    w_next = S_ERR;
            end
            S_ERR:   w_next = S_MUL_P;
            S_MUL_P: w_next = S_MUL_I;
            S_MUL_I: w_next = S_MUL_D;
            S_MUL_D: w_next = S_SUM;
            S_SUM:   w_next = S_DONE;
            S_DONE: begin
                Listo  = 1'b1;
                w_next = S_IDLE;
            end
            default: begin
                Busy   = 1'b0;
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            r_state <= S_IDLE;
            r_r     <= '0;
            r_y     <= '0;
            r_kp    <= '0;
            r_ki    <= '0;
            r_kd    <= '0;
            r_e     <= '0;
            r_de    <= '0;
            r_p     <= '0;
            r_inew  <= '0;
            r_d     <= '0;
            r_iacc  <= '0;
            r_eprev <= '0;
            r_u     <= '0;
            r_sat   <= 1'b0;
        end else begin
            r_state <= w_next;
            case (r_state)
                S_IDLE: begin
                    // Clear lands on the same edge as acceptance, so an update
                    // started together with Clear sees zeroed history.
                    if (Clear) begin
                        r_iacc  <= '0;
                        r_eprev <= '0;
                    end
                    if (Start) begin
                        r_r  <= r;
                        r_y  <= y;
                        r_kp <= Kp;
                        r_ki <= Ki;
                        r_kd <= Kd;
                    end
                end
                S_ERR: begin
                    r_e  <= w_e;
                    r_de <= w_de;
                end
                S_MUL_P: r_p    <= w_mul;
                S_MUL_I: r_inew <= w_isum;
                S_MUL_D: r_d    <= w_mul;
                S_SUM: begin
                    r_u     <= w_u_next;
                    r_sat   <= w_s_ovf;
                    r_eprev <= r_e;
                    if (!w_hold)
                        r_iacc <= r_inew;
                end
                default: ;
            endcase
        end
    end

    assign U           = r_u;
    assign Sat         = r_sat;
    assign o_dbg_state = r_state;
    assign o_dbg_iacc  = r_iacc;

endmodule

// File: tb/tb_pid_secuencial.sv
// -----------------------------------------------------------------------------
// tb_pid_secuencial
//
// Two controller instances share every input: one with anti-windup and one
// without. An arithmetic reference model predicts U, Sat and the integral
// accumulator for each instance. The bench runs directed scenarios and then
// randomized updates, including Start pulses during Busy and input changes
// after acceptance.
// -----------------------------------------------------------------------------
module tb_pid_secuencial;

    localparam int W = 19;
    localparam int F = 8;
    localparam longint MAXV = 2**(W-1) - 1;
    localparam longint MINV = -(2**(W-1));

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic                rst, start, clr;
    logic signed [W-1:0] r, y, kp, ki, kd;

    // Index 0: AW=1, index 1: AW=0
    logic [1:0][W-1:0] u_v;
    logic [1:0][W-1:0] iacc_v;
    logic [1:0][2:0]   st_v;
    logic [1:0]        listo_v, busy_v, sat_v;

    pid_secuencial #(.W(W), .F(F), .AW(1)) dut_aw (
        .CLK(clk), .Reset(rst), .Start(start), .Clear(clr),
        .r(r), .y(y), .Kp(kp), .Ki(ki), .Kd(kd),
        .U(u_v[0]), .Listo(listo_v[0]), .Busy(busy_v[0]), .Sat(sat_v[0]),
        .o_dbg_state(st_v[0]), .o_dbg_iacc(iacc_v[0])
    );

    pid_secuencial #(.W(W), .F(F), .AW(0)) dut_naw (
        .CLK(clk), .Reset(rst), .Start(start), .Clear(clr),
        .r(r), .y(y), .Kp(kp), .Ki(ki), .Kd(kd),
        .U(u_v[1]), .Listo(listo_v[1]), .Busy(busy_v[1]), .Sat(sat_v[1]),
        .o_dbg_state(st_v[1]), .o_dbg_iacc(iacc_v[1])
    );

    // ---------------- scoreboard ----------------
    int total = 0;
    int bad   = 0;

    logic [W-1:0] exp_q[$];
    logic         sat_q[$];

    longint m_iacc[2];
    longint m_eprev[2];
    longint cur_u[2];
    logic   cur_sat[2];

    task automatic check(input string tag, input logic signed [63:0] got,
                         input logic signed [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    function automatic longint msat(input longint x);
        if (x > MAXV) return MAXV;
        if (x < MINV) return MINV;
        return x;
    endfunction

    function automatic longint mmul(input longint a, input longint b);
        return msat((a * b) >>> F);
    endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_iacc[d]  = 0;
            m_eprev[d] = 0;
            cur_u[d]   = 0;
            cur_sat[d] = 1'b0;
        end
        exp_q.delete();
        sat_q.delete();
    endfunction

    function automatic void model_update(input longint rr, input longint yy,
                                         input longint kpv, input longint kiv,
                                         input longint kdv, input bit c);
        for (int d = 0; d < 2; d++) begin
            longint e, de, p, inew, dd, s, u;
            bit     hold;
            if (c) begin
                m_iacc[d]  = 0;
                m_eprev[d] = 0;
            end
            e    = msat(rr - yy);
            de   = msat(e - m_eprev[d]);
            p    = mmul(kpv, e);
            inew = msat(m_iacc[d] + mmul(kiv, e));
            dd   = mmul(kdv, de);
            s    = p + inew + dd;
            u    = msat(s);
            hold = (d == 0) && (((s > MAXV) && (e > 0)) || ((s < MINV) && (e < 0)));
            if (!hold)
                m_iacc[d] = inew;
            m_eprev[d] = e;
            exp_q.push_back(u[W-1:0]);
            sat_q.push_back(s != u);
        end
    endfunction

    function automatic logic signed [W-1:0] rnd(input int mb);
        int x;
        x = int'($urandom_range(0, (2 << mb) - 1)) - (1 << mb);
        return x[W-1:0];
    endfunction

    // ---------------- driver tasks ----------------
    // Entered just after a falling edge with the DUTs idle. Returns just after
    // the falling edge that follows the return to IDLE, so a back-to-back
    // call presents Start to the very next rising edge.
    task automatic run_update(input logic signed [W-1:0] rv, input logic signed [W-1:0] yv,
                              input logic signed [W-1:0] kpv, input logic signed [W-1:0] kiv,
                              input logic signed [W-1:0] kdv, input bit c,
                              input bit repulse, input string tag);
        r     = rv;
        y     = yv;
        kp    = kpv;
        ki    = kiv;
        kd    = kdv;
        clr   = c;
        start = 1'b1;
        model_update(rv, yv, kpv, kiv, kdv, c);
        @(posedge clk);
        for (int i = 0; i <= 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                // The update must use only the values latched at acceptance.
                clr = 1'b0;
                r   = rnd(18);
                y   = rnd(18);
                kp  = rnd(18);
                ki  = rnd(18);
                kd  = rnd(18);
            end
            start = repulse && (i <= 5);
            for (int d = 0; d < 2; d++) begin
                if (i == 5) begin
                    cur_u[d]   = signed'(exp_q.pop_front());
                    cur_sat[d] = sat_q.pop_front();
                end
                check($sformatf("%s_d%0d_c%0d_busy", tag, d, i), 64'(busy_v[d]), 64'(i <= 5));
                check($sformatf("%s_d%0d_c%0d_listo", tag, d, i), 64'(listo_v[d]), 64'(i == 5));
                check($sformatf("%s_d%0d_c%0d_u", tag, d, i), 64'(signed'(u_v[d])), cur_u[d]);
                check($sformatf("%s_d%0d_c%0d_sat", tag, d, i), 64'(sat_v[d]), 64'(cur_sat[d]));
                if (i == 6)
                    check($sformatf("%s_d%0d_iacc", tag, d), 64'(signed'(iacc_v[d])), m_iacc[d]);
            end
        end
    endtask

    task automatic check_cleared(input string tag);
        for (int d = 0; d < 2; d++) begin
            check($sformatf("%s_d%0d_u", tag, d), 64'(signed'(u_v[d])), 0);
            check($sformatf("%s_d%0d_busy", tag, d), 64'(busy_v[d]), 0);
            check($sformatf("%s_d%0d_listo", tag, d), 64'(listo_v[d]), 0);
            check($sformatf("%s_d%0d_sat", tag, d), 64'(sat_v[d]), 0);
            check($sformatf("%s_d%0d_iacc", tag, d), 64'(signed'(iacc_v[d])), 0);
        end
    endtask

    // Reset lands while the DUTs are in MUL_I. No Listo may follow it.
    task automatic reset_mid_update();
        r = 19'sd1000; y = 19'sd400; kp = 19'sd256; ki = 19'sd128; kd = '0;
        start = 1'b1;
        @(posedge clk);
        @(negedge clk);          // ERR
        start = 1'b0;
        @(negedge clk);          // MUL_P
        @(negedge clk);          // MUL_I
        rst = 1'b1;
        @(negedge clk);
        check_cleared("rst_mid");
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                check($sformatf("rst_mid_d%0d_c%0d_listo", d, i), 64'(listo_v[d]), 0);
                check($sformatf("rst_mid_d%0d_c%0d_busy", d, i), 64'(busy_v[d]), 0);
            end
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        rst = 1'b1; start = 1'b0; clr = 1'b0;
        r = '0; y = '0; kp = '0; ki = '0; kd = '0;
        model_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_cleared("reset");
        rst = 1'b0;
        @(negedge clk);

        // Proportional only
        run_update(19'sd1000, 19'sd400, 19'sd256, '0, '0, 1'b0, 1'b0, "tp1");
        check("tp1_u_const", 64'(signed'(u_v[0])), 600);

        // Integral accumulates across updates
        run_update(19'sd100, '0, 19'sd256, 19'sd128, '0, 1'b0, 1'b0, "tp2a");
        check("tp2a_u_const", 64'(signed'(u_v[0])), 150);
        check("tp2a_i_const", 64'(signed'(iacc_v[0])), 50);
        run_update(19'sd100, '0, 19'sd256, 19'sd128, '0, 1'b0, 1'b0, "tp2b");
        check("tp2b_u_const", 64'(signed'(u_v[0])), 200);
        check("tp2b_i_const", 64'(signed'(iacc_v[0])), 100);
        run_update(19'sd100, '0, 19'sd256, 19'sd128, '0, 1'b0, 1'b0, "tp2c");
        check("tp2c_u_const", 64'(signed'(u_v[0])), 250);
        check("tp2c_i_const", 64'(signed'(iacc_v[0])), 150);

        // Derivative, and Clear together with Start
        run_update(19'sd100, '0, '0, '0, 19'sd256, 1'b1, 1'b0, "tp3a");
        check("tp3a_u_const", 64'(signed'(u_v[0])), 100);
        run_update(19'sd300, '0, '0, '0, 19'sd256, 1'b0, 1'b0, "tp3b");
        check("tp3b_u_const", 64'(signed'(u_v[0])), 200);
        run_update(19'sd300, '0, '0, '0, 19'sd256, 1'b1, 1'b0, "tp3c");
        check("tp3c_u_const", 64'(signed'(u_v[0])), 300);

        // Saturation and anti-windup against free integration
        for (int k = 0; k < 3; k++)
            run_update(19'sd262143, -19'sd262144, 19'sd256, 19'sd256, '0, k == 0, 1'b0,
                       $sformatf("tp4_%0d", k));
        check("tp4_u_const", 64'(signed'(u_v[0])), 262143);
        check("tp4_sat_const", 64'(sat_v[0]), 1);
        check("tp4_i_aw_const", 64'(signed'(iacc_v[0])), 0);
        check("tp4_i_naw_const", 64'(signed'(iacc_v[1])), 262143);

        // Start re-pulsed while busy, then accepted back-to-back
        run_update(19'sd500, 19'sd100, 19'sd256, '0, '0, 1'b1, 1'b1, "tp5a");
        run_update(19'sd700, 19'sd100, 19'sd256, '0, '0, 1'b0, 1'b0, "tp5b");
        check("tp5b_u_const", 64'(signed'(u_v[0])), 600);

        // Reset during MUL_I after building up integral state
        run_update(19'sd100, '0, 19'sd256, 19'sd128, '0, 1'b1, 1'b0, "tp6pre");
        reset_mid_update();
        run_update(19'sd1000, 19'sd400, 19'sd256, '0, '0, 1'b0, 1'b0, "tp6");
        check("tp6_u_const", 64'(signed'(u_v[0])), 600);

        // Randomized updates
        for (int n = 0; n < 40; n++) begin
            int mbv, mbk;
            mbv = ($urandom_range(0, 3) == 0) ? 18 : int'($urandom_range(6, 14));
            mbk = ($urandom_range(0, 4) == 0) ? 14 : int'($urandom_range(4, 10));
            run_update(rnd(mbv), rnd(mbv), rnd(mbk), rnd(mbk), rnd(mbk),
                       $urandom_range(0, 7) == 0, $urandom_range(0, 3) == 0,
                       $sformatf("rnd%0d", n));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
